imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 20 ++
 rtl/imem_word_assembler.sv | 36 +++
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned HDR_BYTES      = 2;

  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Shifts bytes MSB-first into a 32-bit word; flags the fourth byte of each word.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  localparam int unsigned ACC_W = WORD_W - BYTE_W;

  logic [ACC_W-1:0] acc_q;
  logic [1:0]       cnt_q;

  assign word_c      = {acc_q, byte_in};
  assign word_done_c = byte_en & (cnt_q == 2'd3);

  // clr has priority so a restart drops any byte presented in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (byte_en) begin
      acc_q <= word_c[ACC_W-1:0];
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte-stream program into instruction memory, then hands the read port to fetch.
// Optional trailing XOR checksum byte when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic [31:0]       cpu_addr,
  output logic [WORD_W-1:0] cpu_instr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned N_W   = HDR_BYTES * BYTE_W;

  state_e            state_q, state_d;
  logic              hdr_cnt_q;
  logic [BYTE_W-1:0] hdr_hi_q;
  logic [N_W-1:0]    n_words_q;
  logic              last_pend_q;
  logic              rx_ready_d;

  logic              byte_hs_c, data_byte_c, finish_c;
  logic [N_W-1:0]    n_hdr_c;
  logic              hdr_bad_c, last_word_c;
  logic [WORD_W-1:0] word_c;
  logic              word_done_c;
  logic              unused_addr_c;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
`endif

  // start beats any byte offered in the same cycle
  assign byte_hs_c   = rx_valid & rx_ready & ~start;
  assign data_byte_c = byte_hs_c & (state_q == ST_DATA);
  assign n_hdr_c     = {hdr_hi_q, rx_data};
  assign hdr_bad_c   = (n_hdr_c == '0) || (32'(n_hdr_c) > DEPTH);
  assign last_word_c = (17'(words_loaded) + 17'd1) == 17'(n_words_q);
  assign finish_c    = word_done_c & last_word_c;

  imem_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start),
    .byte_en     (data_byte_c),
    .byte_in     (rx_data),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  // read port belongs to fetch only once the program is in place
  assign cpu_instr     = cpu_stall ? NOP_WORD : mem_rdata;
  assign mem_addr      = cpu_stall ? mem_waddr : cpu_addr[ADDR_W+1:2];
  assign unused_addr_c = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    rx_ready_d = 1'b0;
    if (start) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (byte_hs_c && (hdr_cnt_q == 1'(HDR_BYTES - 1)))
            state_d = hdr_bad_c ? ST_ERR : ST_DATA;
        end
        ST_DATA: begin
          // last word's write is in flight this cycle
          if (last_pend_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_RUN;
`endif
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        ST_CHK: begin
          if (byte_hs_c)
            state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
    case (state_d)
      ST_HDR, ST_CHK: rx_ready_d = 1'b1;
      ST_DATA:        rx_ready_d = ~finish_c & ~last_pend_q;
      default:        rx_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_ready     <= 1'b0;
      cpu_stall    <= 1'b1;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      hdr_cnt_q    <= 1'b0;
      hdr_hi_q     <= '0;
      n_words_q    <= '0;
      last_pend_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rx_ready  <= rx_ready_d;
      cpu_stall <= (state_d != ST_RUN);
      mem_we    <= 1'b0;
      if (start) begin
        load_err     <= 1'b0;
        words_loaded <= '0;
        hdr_cnt_q    <= 1'b0;
        last_pend_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else begin
        if (mem_we)
          words_loaded <= words_loaded + CNT_W'(1);
        if (byte_hs_c && (state_q == ST_HDR)) begin
          hdr_cnt_q <= ~hdr_cnt_q;
          if (hdr_cnt_q == 1'(HDR_BYTES - 1))
            n_words_q <= n_hdr_c;
          else
            hdr_hi_q <= rx_data;
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (data_byte_c)
          csum_q <= csum_q ^ rx_data;
`endif
        if (word_done_c) begin
          mem_we      <= 1'b1;
          mem_waddr   <= words_loaded[ADDR_W-1:0];
          mem_wdata   <= word_c;
          last_pend_q <= last_word_c;
        end
        if (state_d == ST_ERR)
          load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader; checksum cases follow IMEM_LOAD_CHECKSUM_EN.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic        stall;
    logic [31:0] instr;
    logic        err;
    logic [8:0]  words;
    logic        rdy;
  } st_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_instr;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  logic [31:0] mem [2**ADDR_W];

  wr_t wq[$];
  st_t pq[$];
  int  n_checks;
  int  n_fail;
  logic done;
  logic mon_done;
  logic [7:0] csum;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .cpu_addr     (cpu_addr),
    .cpu_instr    (cpu_instr),
    .cpu_stall    (cpu_stall),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: synchronous write, combinational read
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares every memory write and every status probe
  initial begin
    int cyc;
    wr_t w;
    st_t p;
    cyc = 0;
    mon_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        $display("FAIL watchdog: cycle %0d reached", cyc);
        $fatal(1);
      end
      if (mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got write %h to %h expected none", mem_wdata, mem_waddr);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_waddr), 32'(w.addr));
          chk("wr_data", mem_wdata, w.data);
        end
      end
      while (pq.size() > 0) begin
        p = pq.pop_front();
        chk("cpu_stall", 32'(cpu_stall), 32'(p.stall));
        chk("cpu_instr", cpu_instr, p.instr);
        chk("load_err", 32'(load_err), 32'(p.err));
        chk("words_loaded", 32'(words_loaded), 32'(p.words));
        chk("rx_ready", 32'(rx_ready), 32'(p.rdy));
      end
      if (done) begin
        chk("writes_pending", 32'(wq.size()), 32'd0);
        mon_done = 1'b1;
        break;
      end
    end
  end

  task automatic probe(input logic s, input logic [31:0] i, input logic e,
                       input logic [8:0] wl, input logic r);
    st_t p;
    p.stall = s; p.instr = i; p.err = e; p.words = wl; p.rdy = r;
    pq.push_back(p);
    @(posedge clk); #1;
  endtask

  task automatic exp_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      @(negedge clk);
      hs = rx_ready;
      @(posedge clk); #1;
    end while (!hs);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 3; k >= 0; k--) begin
      send_byte(t[k*8 +: 8]);
      csum = csum ^ t[k*8 +: 8];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    csum = 8'h00;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done = 1'b0; csum = 8'h00;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b0);
    // bytes offered while idle are ignored
    rx_valid = 1'b1; rx_data = 8'hA5;
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b0);
    rx_valid = 1'b0;

    // two-word program
    pulse_start();
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b1);
    send_byte(8'h00); send_byte(8'h02);
    exp_write(8'd0, 32'h2008_0005);
    exp_write(8'd1, 32'h0109_5020);
    send_word(32'h2008_0005);
    send_word(32'h0109_5020);
    probe(1'b1, NOP, 1'b0, 9'd1, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(csum);
`endif
    cpu_addr = 32'd4;
    probe(1'b0, 32'h0109_5020, 1'b0, 9'd2, 1'b0);
    cpu_addr = 32'd0;
    probe(1'b0, 32'h2008_0005, 1'b0, 9'd2, 1'b0);
    cpu_addr = 32'd7;
    probe(1'b0, 32'h0109_5020, 1'b0, 9'd2, 1'b0);
    cpu_addr = 32'h0000_0400;
    rx_valid = 1'b1; rx_data = 8'hFF;
    probe(1'b0, 32'h2008_0005, 1'b0, 9'd2, 1'b0);
    rx_valid = 1'b0;

    // zero-length header
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    probe(1'b1, NOP, 1'b1, 9'd0, 1'b0);
    probe(1'b1, NOP, 1'b1, 9'd0, 1'b0);
    pulse_start();
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b1);

    // N = 257 exceeds depth
    send_byte(8'h01); send_byte(8'h01);
    probe(1'b1, NOP, 1'b1, 9'd0, 1'b0);

    // N = 256 is legal; abort after three bytes with a byte colliding with start
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rx_valid = 1'b1; rx_data = 8'hDD;
    pulse_start();
    rx_valid = 1'b0;
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b1);
    send_byte(8'h00); send_byte(8'h01);
    exp_write(8'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    probe(1'b1, NOP, 1'b0, 9'd0, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(csum);
`endif
    cpu_addr = 32'd0;
    probe(1'b0, 32'h1234_5678, 1'b0, 9'd1, 1'b0);
    cpu_addr = 32'd4;
    probe(1'b0, 32'h0109_5020, 1'b0, 9'd1, 1'b0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // corrupted checksum
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    exp_write(8'd0, 32'h2008_0005);
    exp_write(8'd1, 32'h0109_5020);
    send_word(32'h2008_0005);
    send_word(32'h0109_5020);
    send_byte(csum ^ 8'h01);
    probe(1'b1, NOP, 1'b1, 9'd2, 1'b0);
    probe(1'b1, NOP, 1'b1, 9'd2, 1'b0);
`endif

    done = 1'b1;
    wait (mon_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
